// File: rtl/id_stage_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : id_stage_pipe_if
// Purpose  : Signal bundle between IF/ID, WB, hazard sources and the ID/EX register.
// Revision : 1.0  initial release
// ============================================================================
interface id_stage_pipe_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4
);
  // IF/ID side and stage controls
  logic              instr_valid;
  logic [31:0]       instruction;
  logic [DATA_W-1:0] pc_in;
  logic [3:0]        sr;
  logic              flush;
  logic              freeze;
  // writeback port
  logic              wb_wb_en;
  logic [REG_AW-1:0] wb_dest;
  logic [DATA_W-1:0] wb_value;
  // downstream producers
  logic              exe_wb_en;
  logic              exe_mem_r_en;
  logic [REG_AW-1:0] exe_dest;
  logic              mem_wb_en;
  logic [REG_AW-1:0] mem_dest;
  // stage results
  logic              hazard;
  logic              out_valid;
  logic              wb_en;
  logic              mem_r_en;
  logic              mem_w_en;
  logic              branch;
  logic              s;
  logic              imm;
  logic              two_src;
  logic [3:0]        exe_cmd;
  logic [DATA_W-1:0] val_rn;
  logic [DATA_W-1:0] val_rm;
  logic [DATA_W-1:0] pc_out;
  logic [11:0]       shift_operand;
  logic [23:0]       signed_imm_24;
  logic [REG_AW-1:0] dest;
  logic [REG_AW-1:0] src1;
  logic [REG_AW-1:0] src2;

  modport master (
    output instr_valid, instruction, pc_in, sr, flush, freeze,
    output wb_wb_en, wb_dest, wb_value,
    output exe_wb_en, exe_mem_r_en, exe_dest, mem_wb_en, mem_dest,
    input  hazard, out_valid, wb_en, mem_r_en, mem_w_en, branch, s, imm, two_src,
    input  exe_cmd, val_rn, val_rm, pc_out, shift_operand, signed_imm_24,
    input  dest, src1, src2
  );

  modport slave (
    input  instr_valid, instruction, pc_in, sr, flush, freeze,
    input  wb_wb_en, wb_dest, wb_value,
    input  exe_wb_en, exe_mem_r_en, exe_dest, mem_wb_en, mem_dest,
    output hazard, out_valid, wb_en, mem_r_en, mem_w_en, branch, s, imm, two_src,
    output exe_cmd, val_rn, val_rm, pc_out, shift_operand, signed_imm_24,
    output dest, src1, src2
  );
endinterface
`default_nettype wire

// File: rtl/id_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module   : id_stage_pipe
// Purpose  : Decode, condition check, bypassed register file, hazard detect and
//            registered ID/EX outputs. Define FORWARDING_EN for load-use-only hazards.
// Revision : 1.0  initial release
// ============================================================================
module id_stage_pipe #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  id_stage_pipe_if.slave    bus
);

  localparam int NUM_REGS = 2 ** REG_AW;

  localparam logic [1:0] MODE_ARITH  = 2'b00;
  localparam logic [1:0] MODE_MEM    = 2'b01;
  localparam logic [1:0] MODE_BRANCH = 2'b10;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  localparam logic [3:0] CMD_NOP = 4'b0000;
  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MVN = 4'b1001;

  // Field extraction
  logic [3:0]        w_cond;
  logic [1:0]        w_mode;
  logic              w_i_bit;
  logic [3:0]        w_opcode;
  logic              w_s_bit;
  logic [REG_AW-1:0] w_src1;
  logic [REG_AW-1:0] w_src2;
  logic [REG_AW-1:0] w_dest;

  assign w_cond   = bus.instruction[31:28];
  assign w_mode   = bus.instruction[27:26];
  assign w_i_bit  = bus.instruction[25];
  assign w_opcode = bus.instruction[24:21];
  assign w_s_bit  = bus.instruction[20];
  assign w_src1   = REG_AW'(bus.instruction[19:16]);
  assign w_dest   = REG_AW'(bus.instruction[15:12]);

  // Control table
  logic [3:0] w_cmd;
  logic       w_wb;
  logic       w_mem_r;
  logic       w_mem_w;
  logic       w_branch;
  logic       w_s;
  logic       w_move;

  always_comb begin
    w_cmd    = CMD_NOP;
    w_wb     = 1'b0;
    w_mem_r  = 1'b0;
    w_mem_w  = 1'b0;
    w_branch = 1'b0;
    w_s      = 1'b0;
    w_move   = 1'b0;
    case (w_mode)
      MODE_ARITH: begin
        w_s = w_s_bit;
        case (w_opcode)
          OP_MOV: begin w_cmd = CMD_MOV; w_wb = 1'b1; w_move = 1'b1; end
          OP_MVN: begin w_cmd = CMD_MVN; w_wb = 1'b1; w_move = 1'b1; end
          OP_ADD: begin w_cmd = CMD_ADD; w_wb = 1'b1; end
          OP_ADC: begin w_cmd = CMD_ADC; w_wb = 1'b1; end
          OP_SUB: begin w_cmd = CMD_SUB; w_wb = 1'b1; end
          OP_SBC: begin w_cmd = CMD_SBC; w_wb = 1'b1; end
          OP_AND: begin w_cmd = CMD_AND; w_wb = 1'b1; end
          OP_ORR: begin w_cmd = CMD_ORR; w_wb = 1'b1; end
          OP_EOR: begin w_cmd = CMD_EOR; w_wb = 1'b1; end
          OP_CMP: w_cmd = CMD_SUB;
          OP_TST: w_cmd = CMD_AND;
          default: w_s = 1'b0;
        endcase
      end
      MODE_MEM: begin
        // The S bit doubles as the load/store selector; address is Rn + offset.
        w_cmd = CMD_ADD;
        if (w_s_bit) begin
          w_mem_r = 1'b1;
          w_wb    = 1'b1;
        end else begin
          w_mem_w = 1'b1;
        end
      end
      MODE_BRANCH: w_branch = 1'b1;
      default: ;
    endcase
  end

  // Condition check against N,Z,C,V
  logic w_n, w_z, w_c, w_v;
  logic w_cond_pass;

  assign {w_n, w_z, w_c, w_v} = bus.sr;

  always_comb begin
    w_cond_pass = 1'b0;
    case (w_cond)
      4'b0000: w_cond_pass = w_z;
      4'b0001: w_cond_pass = ~w_z;
      4'b0010: w_cond_pass = w_c;
      4'b0011: w_cond_pass = ~w_c;
      4'b0100: w_cond_pass = w_n;
      4'b0101: w_cond_pass = ~w_n;
      4'b0110: w_cond_pass = w_v;
      4'b0111: w_cond_pass = ~w_v;
      4'b1000: w_cond_pass = w_c & ~w_z;
      4'b1001: w_cond_pass = ~w_c | w_z;
      4'b1010: w_cond_pass = (w_n == w_v);
      4'b1011: w_cond_pass = (w_n != w_v);
      4'b1100: w_cond_pass = ~w_z & (w_n == w_v);
      4'b1101: w_cond_pass = w_z | (w_n != w_v);
      4'b1110: w_cond_pass = 1'b1;
      default: w_cond_pass = 1'b0;
    endcase
  end

  logic w_two_src;
  logic w_uses_rn;

  assign w_src2    = w_mem_w ? REG_AW'(bus.instruction[15:12]) : REG_AW'(bus.instruction[3:0]);
  assign w_two_src = (~w_i_bit & (w_mode == MODE_ARITH)) | w_mem_w;
  assign w_uses_rn = ~w_branch & ~w_move;

  // Register file with write-first read bypass
  logic [DATA_W-1:0] r_rf [NUM_REGS];
  logic [DATA_W-1:0] w_val_rn;
  logic [DATA_W-1:0] w_val_rm;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        r_rf[k] <= '0;
      end
    end else if (bus.wb_wb_en) begin
      r_rf[bus.wb_dest] <= bus.wb_value;
    end
  end

  assign w_val_rn = (bus.wb_wb_en && (bus.wb_dest == w_src1)) ? bus.wb_value : r_rf[w_src1];
  assign w_val_rm = (bus.wb_wb_en && (bus.wb_dest == w_src2)) ? bus.wb_value : r_rf[w_src2];

  // Hazard detection
  logic w_hazard_core;

`ifdef FORWARDING_EN
  logic w_unused_mem_fwd;
  assign w_unused_mem_fwd = bus.mem_wb_en ^ (^bus.mem_dest);
  assign w_hazard_core = bus.instr_valid & bus.exe_mem_r_en & bus.exe_wb_en &
                         ((w_uses_rn & (bus.exe_dest == w_src1)) |
                          (w_two_src & (bus.exe_dest == w_src2)));
`else
  logic w_unused_exe_load;
  logic w_rn_busy;
  logic w_rm_busy;
  assign w_unused_exe_load = bus.exe_mem_r_en;
  assign w_rn_busy = (bus.exe_wb_en & (bus.exe_dest == w_src1)) |
                     (bus.mem_wb_en & (bus.mem_dest == w_src1));
  assign w_rm_busy = (bus.exe_wb_en & (bus.exe_dest == w_src2)) |
                     (bus.mem_wb_en & (bus.mem_dest == w_src2));
  assign w_hazard_core = bus.instr_valid & ((w_uses_rn & w_rn_busy) | (w_two_src & w_rm_busy));
`endif

  // Reset only masks the visible hazard; the flops are held in reset anyway.
  assign bus.hazard = rst & w_hazard_core;

  logic w_issue;
  assign w_issue = bus.instr_valid & w_cond_pass & ~w_hazard_core & ~bus.flush;

  // ID/EX pipeline register
  logic              r_out_valid, r_wb_en, r_mem_r_en, r_mem_w_en, r_branch, r_s;
  logic              r_imm, r_two_src;
  logic [3:0]        r_exe_cmd;
  logic [DATA_W-1:0] r_val_rn, r_val_rm, r_pc_out;
  logic [11:0]       r_shift_operand;
  logic [23:0]       r_signed_imm_24;
  logic [REG_AW-1:0] r_dest, r_src1, r_src2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid     <= 1'b0;
      r_wb_en         <= 1'b0;
      r_mem_r_en      <= 1'b0;
      r_mem_w_en      <= 1'b0;
      r_branch        <= 1'b0;
      r_s             <= 1'b0;
      r_imm           <= 1'b0;
      r_two_src       <= 1'b0;
      r_exe_cmd       <= CMD_NOP;
      r_val_rn        <= '0;
      r_val_rm        <= '0;
      r_pc_out        <= '0;
      r_shift_operand <= '0;
      r_signed_imm_24 <= '0;
      r_dest          <= '0;
      r_src1          <= '0;
      r_src2          <= '0;
    end else if (!bus.freeze) begin
      r_out_valid     <= w_issue;
      r_wb_en         <= w_issue & w_wb;
      r_mem_r_en      <= w_issue & w_mem_r;
      r_mem_w_en      <= w_issue & w_mem_w;
      r_branch        <= w_issue & w_branch;
      r_s             <= w_issue & w_s;
      r_exe_cmd       <= w_issue ? w_cmd : CMD_NOP;
      r_imm           <= w_i_bit;
      r_two_src       <= w_two_src;
      r_val_rn        <= w_val_rn;
      r_val_rm        <= w_val_rm;
      r_pc_out        <= bus.pc_in;
      r_shift_operand <= bus.instruction[11:0];
      r_signed_imm_24 <= bus.instruction[23:0];
      r_dest          <= w_dest;
      r_src1          <= w_src1;
      r_src2          <= w_src2;
    end
  end

  assign bus.out_valid     = r_out_valid;
  assign bus.wb_en         = r_wb_en;
  assign bus.mem_r_en      = r_mem_r_en;
  assign bus.mem_w_en      = r_mem_w_en;
  assign bus.branch        = r_branch;
  assign bus.s             = r_s;
  assign bus.imm           = r_imm;
  assign bus.two_src       = r_two_src;
  assign bus.exe_cmd       = r_exe_cmd;
  assign bus.val_rn        = r_val_rn;
  assign bus.val_rm        = r_val_rm;
  assign bus.pc_out        = r_pc_out;
  assign bus.shift_operand = r_shift_operand;
  assign bus.signed_imm_24 = r_signed_imm_24;
  assign bus.dest          = r_dest;
  assign bus.src1          = r_src1;
  assign bus.src2          = r_src2;

endmodule
`default_nettype wire

// File: tb/tb_id_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_stage_pipe
// Purpose  : Directed self-checking bench for id_stage_pipe.
// Revision : 1.0  initial release
// ============================================================================
module tb_id_stage_pipe;

  localparam int DATA_W = 32;
  localparam int REG_AW = 4;

  localparam logic [31:0] I_ADD   = 32'hE0821003; // ADD   R1,R2,R3
  localparam logic [31:0] I_ADDEQ = 32'h00821003; // ADDEQ R1,R2,R3
  localparam logic [31:0] I_MOV   = 32'hE3A06005; // MOV   R6,#5
  localparam logic [31:0] I_STR   = 32'hE4854000; // STR   R4,[R5]
  localparam logic [31:0] I_LDR   = 32'hE4987000; // LDR   R7,[R8]
  localparam logic [31:0] I_B     = 32'hEA000010; // B     +0x10
  localparam logic [31:0] I_CMP   = 32'hE1510002; // CMPS  R1,R2

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  id_stage_pipe_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) bus ();

  id_stage_pipe #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   errors = 0;
  int   checks = 0;
  logic exp_hz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
`ifdef FORWARDING_EN
    exp_hz = 1'b0;
`else
    exp_hz = 1'b1;
`endif
    bus.instr_valid  = 1'b0;
    bus.instruction  = 32'h0;
    bus.pc_in        = '0;
    bus.sr           = 4'b0000;
    bus.flush        = 1'b0;
    bus.freeze       = 1'b0;
    bus.wb_wb_en     = 1'b0;
    bus.wb_dest      = '0;
    bus.wb_value     = '0;
    bus.exe_wb_en    = 1'b0;
    bus.exe_mem_r_en = 1'b0;
    bus.exe_dest     = '0;
    bus.mem_wb_en    = 1'b0;
    bus.mem_dest     = '0;

    tick;
    tick;
    // Reset held with a would-be hazard on the inputs
    bus.instr_valid = 1'b1;
    bus.instruction = I_ADD;
    bus.exe_wb_en   = 1'b1;
    bus.exe_dest    = 4'd2;
    #1;
    chk("rst_hazard", 32'(bus.hazard), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_val_rn", bus.val_rn, 0);
    chk("rst_pc_out", bus.pc_out, 0);

    // Release reset, preload R3 with no instruction present
    @(negedge clk);
    rst             = 1'b1;
    bus.instr_valid = 1'b0;
    bus.exe_wb_en   = 1'b0;
    bus.wb_wb_en    = 1'b1;
    bus.wb_dest     = 4'd3;
    bus.wb_value    = 32'h0000_0033;
    tick;
    chk("idle_out_valid", 32'(bus.out_valid), 0);

    // Same-cycle writeback bypass into Rn
    bus.wb_dest     = 4'd2;
    bus.wb_value    = 32'hDEAD_BEEF;
    bus.instr_valid = 1'b1;
    bus.instruction = I_ADD;
    bus.pc_in       = 32'h0000_0104;
    tick;
    chk("byp_val_rn", bus.val_rn, 32'hDEAD_BEEF);
    chk("byp_val_rm", bus.val_rm, 32'h0000_0033);
    chk("byp_exe_cmd", 32'(bus.exe_cmd), 32'h2);
    chk("byp_out_valid", 32'(bus.out_valid), 1);
    chk("byp_wb_en", 32'(bus.wb_en), 1);
    chk("byp_dest", 32'(bus.dest), 1);
    chk("byp_src1", 32'(bus.src1), 2);
    chk("byp_src2", 32'(bus.src2), 3);
    chk("byp_two_src", 32'(bus.two_src), 1);
    chk("byp_pc_out", bus.pc_out, 32'h0000_0104);

    // ADDEQ with Z clear: bubble, data still loads
    bus.wb_wb_en    = 1'b0;
    bus.instruction = I_ADDEQ;
    bus.sr          = 4'b0000;
    tick;
    chk("eq_fail_out_valid", 32'(bus.out_valid), 0);
    chk("eq_fail_wb_en", 32'(bus.wb_en), 0);
    chk("eq_fail_exe_cmd", 32'(bus.exe_cmd), 0);
    chk("eq_fail_val_rn", bus.val_rn, 32'hDEAD_BEEF);
    chk("eq_fail_dest", 32'(bus.dest), 1);

    // ADDEQ with Z set
    bus.sr = 4'b0100;
    tick;
    chk("eq_pass_out_valid", 32'(bus.out_valid), 1);
    chk("eq_pass_exe_cmd", 32'(bus.exe_cmd), 32'h2);

    // EXE producer writes Rn
    bus.sr          = 4'b0000;
    bus.instruction = I_ADD;
    bus.exe_wb_en   = 1'b1;
    bus.exe_dest    = 4'd2;
    #1;
    chk("hz_exe_rn", 32'(bus.hazard), 32'(exp_hz));
    @(negedge clk);
    tick;
    chk("hz_exe_rn_out_valid", 32'(bus.out_valid), 32'(!exp_hz));
    chk("hz_exe_rn_wb_en", 32'(bus.wb_en), 32'(!exp_hz));

    // EXE producer writes Rm
    bus.exe_dest = 4'd3;
    #1;
    chk("hz_exe_rm", 32'(bus.hazard), 32'(exp_hz));
    @(negedge clk);

    // Unrelated EXE destination
    bus.exe_dest = 4'd4;
    #1;
    chk("hz_none", 32'(bus.hazard), 0);
    @(negedge clk);
    tick;
    chk("hz_none_out_valid", 32'(bus.out_valid), 1);

    // MOV ignores Rn field even when it matches the EXE destination
    bus.instruction = I_MOV;
    bus.exe_dest    = 4'd0;
    #1;
    chk("mov_no_hz", 32'(bus.hazard), 0);
    @(negedge clk);
    tick;
    chk("mov_exe_cmd", 32'(bus.exe_cmd), 32'h1);
    chk("mov_imm", 32'(bus.imm), 1);
    chk("mov_shift_operand", 32'(bus.shift_operand), 32'h005);
    chk("mov_dest", 32'(bus.dest), 6);
    chk("mov_two_src", 32'(bus.two_src), 0);

    // STR: Rd is the second source; MEM producer on R4
    bus.exe_wb_en   = 1'b0;
    bus.instruction = I_STR;
    bus.mem_wb_en   = 1'b1;
    bus.mem_dest    = 4'd4;
    #1;
    chk("str_hz_mem", 32'(bus.hazard), 32'(exp_hz));
    @(negedge clk);
    tick;
    chk("str_hz_mem_w_en", 32'(bus.mem_w_en), 32'(!exp_hz));
    chk("str_src2", 32'(bus.src2), 4);
    chk("str_two_src", 32'(bus.two_src), 1);

    bus.mem_wb_en = 1'b0;
    tick;
    chk("str_mem_w_en", 32'(bus.mem_w_en), 1);
    chk("str_out_valid", 32'(bus.out_valid), 1);
    chk("str_exe_cmd", 32'(bus.exe_cmd), 32'h2);
    chk("str_wb_en", 32'(bus.wb_en), 0);

    // Branch, then freeze+flush hold, then flush bubble
    bus.instruction = I_B;
    bus.pc_in       = 32'h0000_0200;
    tick;
    chk("b_branch", 32'(bus.branch), 1);
    chk("b_imm24", 32'(bus.signed_imm_24), 32'h00_0010);
    chk("b_exe_cmd", 32'(bus.exe_cmd), 0);

    bus.instruction = I_LDR;
    bus.pc_in       = 32'h0000_0300;
    bus.freeze      = 1'b1;
    bus.flush       = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("frz_branch", 32'(bus.branch), 1);
      chk("frz_out_valid", 32'(bus.out_valid), 1);
      chk("frz_pc_out", bus.pc_out, 32'h0000_0200);
    end

    bus.freeze = 1'b0;
    tick;
    chk("flush_out_valid", 32'(bus.out_valid), 0);
    chk("flush_branch", 32'(bus.branch), 0);
    chk("flush_mem_r_en", 32'(bus.mem_r_en), 0);
    chk("flush_dest", 32'(bus.dest), 7);
    chk("flush_pc_out", bus.pc_out, 32'h0000_0300);

    bus.flush = 1'b0;
    tick;
    chk("ldr_mem_r_en", 32'(bus.mem_r_en), 1);
    chk("ldr_wb_en", 32'(bus.wb_en), 1);
    chk("ldr_exe_cmd", 32'(bus.exe_cmd), 32'h2);
    chk("ldr_two_src", 32'(bus.two_src), 0);

    // CMPS: flags only
    bus.instruction = I_CMP;
    tick;
    chk("cmp_s", 32'(bus.s), 1);
    chk("cmp_wb_en", 32'(bus.wb_en), 0);
    chk("cmp_exe_cmd", 32'(bus.exe_cmd), 32'h4);

    // Mid-run asynchronous reset with a live hazard on the inputs
    bus.exe_wb_en = 1'b1;
    bus.exe_dest  = 4'd1;
    rst           = 1'b0;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 0);
    chk("arst_exe_cmd", 32'(bus.exe_cmd), 0);
    chk("arst_val_rn", bus.val_rn, 0);
    chk("arst_pc_out", bus.pc_out, 0);
    chk("arst_s", 32'(bus.s), 0);
    chk("arst_hazard", 32'(bus.hazard), 0);

    @(negedge clk);
    rst           = 1'b1;
    bus.exe_wb_en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.instruction = 32'hE080_0000 | (32'(i) << 16) | 32'(i);
      tick;
      chk($sformatf("rf_clear_rn_r%0d", i), bus.val_rn, 0);
      chk($sformatf("rf_clear_rm_r%0d", i), bus.val_rm, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/id_stage_pipe.md
# id_stage_pipe

Parametrised decode stage for the ARM-subset pipeline. It combines instruction decode, condition check, a register file with write-through bypass, hazard detection and the ID/EX pipeline register in one block. It sits between the IF/ID register and the EXE stage, and honours the SRAM-driven freeze and the EXE branch flush. Unlike the previous decode stage, its outputs are registered and the data width and register count are configurable; operand forwarding is optional.

## Interface
- DATA_W, 32, datapath width for register values, PC and WB value
- REG_AW, 4, register index width; NUM_REGS = 2**REG_AW
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- instr_valid  in  1  IF/ID holds a real instruction
- instruction  in  32  encoded instruction
- pc_in  in  DATA_W  PC+4 of the instruction
- sr  in  4  status flags N,Z,C,V
- flush  in  1  branch taken in EXE
- freeze  in  1  SRAM busy; hold the stage
- wb_wb_en  in  1  writeback enable
- wb_dest  in  REG_AW  writeback register
- wb_value  in  DATA_W  writeback data
- exe_wb_en, exe_mem_r_en  in  1 each  EXE-stage instruction controls
- exe_dest  in  REG_AW  EXE-stage destination register
- mem_wb_en  in  1  MEM-stage writeback enable
- mem_dest  in  REG_AW  MEM-stage destination register
- hazard  out  1  combinational; stalls PC and IF/ID
- out_valid, wb_en, mem_r_en, mem_w_en, branch, s, imm, two_src  out  1 each  registered
- exe_cmd  out  4  registered
- val_rn, val_rm, pc_out  out  DATA_W  registered
- shift_operand  out  12  registered
- signed_imm_24  out  24  registered
- dest, src1, src2  out  REG_AW  registered

## Operation
- Field extraction:
  - cond = [31:28], mode = [27:26], I = [25], opcode = [24:21], S = [20]
  - src1 = [19:16]
  - src2 = mem_write ? [15:12] : [3:0]
  - dest = [15:12]
- Decode reuses the team's control table and condition-check logic.
- two_src = (~I & mode==00) | mem_write.
- uses_rn = ~branch & ~move.
- Register file:
  - NUM_REGS × DATA_W; all entries cleared on reset.
  - Written at posedge when wb_wb_en is high.
  - Reads are combinational and write-first: if wb_wb_en and wb_dest equals the read index, wb_value is returned.
- Bubble condition: bubble = ~instr_valid | ~cond_pass | hazard.
  - On a bubble, wb_en, mem_r_en, mem_w_en, branch, s and out_valid load 0 and exe_cmd loads 0.
  - Data fields still load.
- Hazard is defined in Configuration and is always gated by instr_valid.
- Pipeline register update, by priority:
  - ~rst: clear everything.
  - freeze: hold all outputs.
  - flush: load a bubble.
  - otherwise: load the decoded instruction, or a bubble per the rule above.
- Freeze takes priority over flush. The EXE branch is frozen too, so flush is still asserted on the cycle freeze drops.

## Timing
- Latency: the instruction present at edge N appears on the outputs after edge N.
- hazard is combinational within the cycle and carries no register.
- A writeback in the same cycle as a read is visible to that read through the bypass.
- Reset values: every registered output is 0, including val_rn, val_rm and pc_out.
- hazard is 0 while rst is low.
- Reset deasserted mid-freeze: the first edge after reset loads normally if freeze is low.
- A sustained hazard produces one bubble per cycle until the producer leaves EXE/MEM.

## Configuration
- FORWARDING_EN defined:
  - EXE supplies the forwarding muxes.
  - hazard fires only for load-use: exe_mem_r_en & exe_wb_en & ((uses_rn & exe_dest==src1) | (two_src & exe_dest==src2)).
- FORWARDING_EN undefined:
  - hazard fires when (exe_wb_en & exe_dest==s) | (mem_wb_en & mem_dest==s).
  - s = src1 when uses_rn, and s = src2 when two_src.

## Test plan
- Reset: pulse rst low mid-run -> all outputs 0 immediately; R0..R15 read 0 afterwards.
- Bypass:
  - Stimulus: wb_wb_en=1, wb_dest=2, wb_value=0xDEADBEEF together with ADD R1,R2,R3 (0xE0821003).
  - Required response: next cycle val_rn=0xDEADBEEF and exe_cmd=ADD.
- Condition fail:
  - Stimulus: ADDEQ with sr Z=0.
  - Required response: out_valid=0, wb_en=0 and exe_cmd=0 next cycle.
- Hazard without FORWARDING_EN:
  - Stimulus: exe_wb_en=1, exe_dest=2, decode of ADD R1,R2,R3.
  - Required response: hazard=1 and a bubble is loaded.
  - With the macro defined, the same stimulus gives hazard=0 unless exe_mem_r_en=1.
- Freeze vs flush:
  - Stimulus: freeze=1 and flush=1 for 3 cycles, then freeze=0.
  - Required response: outputs hold for 3 cycles, then a bubble is loaded on the next edge.
- STR R4,[R5]: src2=4, two_src=1, mem_w_en=1; hazard is raised when mem_wb_en=1 and mem_dest=4 (no forwarding).
